// File: rtl/memory_stage_pkg.sv
// Shared definitions for the OTTER memory stage: FSM states, access size
// encodings and the default bus wait-state limit.
package memory_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: byte enables and replicated store
// data, the alignment check, and load-data extraction with sign/zero extension.
// Size encoding 3 behaves as a word.
module mem_lane_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]  addr_off,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store-side lane placement and alignment check.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        byte_en    = 4'b1111;
        write_data = store_data;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_off;
                write_data = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = 4'b0011 << addr_off;
                write_data = {2{store_data[15:0]}};
                misaligned = addr_off[0];
            end
            default: begin
                misaligned = (addr_off != 2'b00);
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_half = addr_off[1] ? read_data[31:16] : read_data[15:0];
        case (addr_off)
            2'd0:    ld_byte = read_data[7:0];
            2'd1:    ld_byte = read_data[15:8];
            2'd2:    ld_byte = read_data[23:16];
            default: ld_byte = read_data[31:24];
        endcase
        case (size)
            SIZE_BYTE: load_data = {{24{~load_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = {{16{~load_unsigned & ld_half[15]}}, ld_half};
            default:   load_data = read_data;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// OTTER memory stage: issues at most one data-memory access per instruction
// over a req/ready bus, stalls upstream while the bus is busy, and loads the
// MEM/WB register. Optional bus-abort watchdog enabled by MEMORY_TIMEOUT_EN.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        MEMORY_CLOCK,
    input  logic        MEMORY_RESET,
    input  logic [31:0] EXEC_PC_4,
    input  logic [31:0] EXEC_PC_MEM,
    input  logic [31:0] EXEC_ALU_RESULT,
    input  logic [31:0] EXEC_RS2,
    input  logic [1:0]  EXEC_RF_WR_SEL,
    input  logic        EXEC_REGWRITE,
    input  logic        EXEC_MEMWRITE,
    input  logic        EXEC_MEMREAD2,
    input  logic [1:0]  EXEC_MEM_SIZE,
    input  logic        EXEC_MEM_UNSIGNED,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    input  logic        DMEM_READY,
    input  logic [31:0] DMEM_RDATA,
    output logic        MEM_STALL,
    output logic [31:0] MEM_PC_4,
    output logic [31:0] MEM_ALU_RESULT,
    output logic [31:0] MEM_DOUT2,
    output logic [1:0]  MEM_RF_WR_SEL,
    output logic        MEM_REGWRITE,
    output logic        MEM_MISALIGN,
    output logic        MEM_BUS_ERR
);

    mem_state_t  state;
    logic        is_access;
    logic        is_load;
    logic        misaligned;
    logic        bus_complete;
    logic        timeout_hit;
    logic [31:0] load_data;

    // The PC of the memory instruction itself is not consumed in this stage.
    logic        unused_pc_mem;
    assign unused_pc_mem = ^EXEC_PC_MEM;

    // A store wins when both control bits are set.
    assign is_access = EXEC_MEMREAD2 | EXEC_MEMWRITE;
    assign is_load   = EXEC_MEMREAD2 & ~EXEC_MEMWRITE;

    mem_lane_align u_lane_align (
        .addr_off      (EXEC_ALU_RESULT[1:0]),
        .size          (EXEC_MEM_SIZE),
        .load_unsigned (EXEC_MEM_UNSIGNED),
        .store_data    (EXEC_RS2),
        .read_data     (DMEM_RDATA),
        .byte_en       (DMEM_BE),
        .write_data    (DMEM_WDATA),
        .misaligned    (misaligned),
        .load_data     (load_data)
    );

    // Request fields come straight from the execute register, which upstream
    // holds stable while stalled, so they stay constant for the whole request.
    assign DMEM_WE      = EXEC_MEMWRITE;
    assign DMEM_ADDR    = {EXEC_ALU_RESULT[31:2], 2'b00};
    assign DMEM_REQ     = MEMORY_RESET & ((state == ST_WAIT) | (is_access & ~misaligned));
    assign bus_complete = DMEM_REQ & DMEM_READY;
    assign MEM_STALL    = DMEM_REQ & ~DMEM_READY & ~timeout_hit;

`ifdef MEMORY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_count;

    // Abort on the cycle that would be the TIMEOUT_CYCLES-th wait state without READY.
    assign timeout_hit = (state == ST_WAIT) & ~DMEM_READY &
                         (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in WAIT; cleared whenever WAIT is left.
    always_ff @(posedge MEMORY_CLOCK) begin
        if (!MEMORY_RESET) begin
            wait_count <= '0;
        end else if (state == ST_WAIT && !DMEM_READY && !timeout_hit) begin
            wait_count <= wait_count + 1'b1;
        end else begin
            wait_count <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Bus handshake sequencing: IDLE issues, WAIT holds until READY or abort.
    always_ff @(posedge MEMORY_CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!MEMORY_RESET) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (DMEM_REQ && !DMEM_READY) state <= ST_WAIT;
                ST_WAIT: if (DMEM_READY || timeout_hit) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: pass-through or load data on completion, bubble otherwise.
    always_ff @(posedge MEMORY_CLOCK) begin
        // NOTE: this is a handful of pipeline flops, not a memory array, so every field is reset.
        if (!MEMORY_RESET) begin
            MEM_PC_4       <= '0;
            MEM_ALU_RESULT <= '0;
            MEM_DOUT2      <= '0;
            MEM_RF_WR_SEL  <= '0;
            MEM_REGWRITE   <= 1'b0;
            MEM_MISALIGN   <= 1'b0;
            MEM_BUS_ERR    <= 1'b0;
        end else begin
            MEM_PC_4       <= EXEC_PC_4;
            MEM_ALU_RESULT <= EXEC_ALU_RESULT;
            MEM_RF_WR_SEL  <= EXEC_RF_WR_SEL;
            MEM_REGWRITE   <= EXEC_REGWRITE & (~is_access | bus_complete);
            MEM_DOUT2      <= (is_load & bus_complete) ? load_data : '0;
            MEM_MISALIGN   <= is_access & misaligned & (state == ST_IDLE);
            MEM_BUS_ERR    <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage. Expected MEM/WB entries are queued
// when an instruction is driven and compared by a monitor on the cycle the
// bench expects the entry to retire; every other cycle must be a bubble.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int TMO = 16;

    bit          clk;
    logic        rst_n;
    logic [31:0] EXEC_PC_4, EXEC_PC_MEM, EXEC_ALU_RESULT, EXEC_RS2;
    logic [1:0]  EXEC_RF_WR_SEL, EXEC_MEM_SIZE;
    logic        EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2, EXEC_MEM_UNSIGNED;
    logic        DMEM_REQ, DMEM_WE, DMEM_READY;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BE;
    logic        MEM_STALL, MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR;
    logic [31:0] MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2;
    logic [1:0]  MEM_RF_WR_SEL;

    memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .MEMORY_CLOCK(clk), .MEMORY_RESET(rst_n),
        .EXEC_PC_4(EXEC_PC_4), .EXEC_PC_MEM(EXEC_PC_MEM),
        .EXEC_ALU_RESULT(EXEC_ALU_RESULT), .EXEC_RS2(EXEC_RS2),
        .EXEC_RF_WR_SEL(EXEC_RF_WR_SEL), .EXEC_REGWRITE(EXEC_REGWRITE),
        .EXEC_MEMWRITE(EXEC_MEMWRITE), .EXEC_MEMREAD2(EXEC_MEMREAD2),
        .EXEC_MEM_SIZE(EXEC_MEM_SIZE), .EXEC_MEM_UNSIGNED(EXEC_MEM_UNSIGNED),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_READY(DMEM_READY),
        .DMEM_RDATA(DMEM_RDATA), .MEM_STALL(MEM_STALL),
        .MEM_PC_4(MEM_PC_4), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_DOUT2(MEM_DOUT2),
        .MEM_RF_WR_SEL(MEM_RF_WR_SEL), .MEM_REGWRITE(MEM_REGWRITE),
        .MEM_MISALIGN(MEM_MISALIGN), .MEM_BUS_ERR(MEM_BUS_ERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc4, alu, rs2;
        logic [1:0]  sel;
        logic        rw, mw, mr;
        logic [1:0]  size;
        logic        uns;
    } exec_t;

    typedef struct {
        string       tag;
        bit          full;
        logic [31:0] pc4, alu, dout2;
        logic [1:0]  sel;
        logic        rw, mis, berr;
    } entry_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } bus_t;

    entry_t sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     retire_now, mon_due, mon_rst, mon_active;
    exec_t  nop_ex;

    function automatic exec_t mk(input logic [31:0] pc4, alu, rs2, input logic [1:0] sel,
                                 input logic rw, mw, mr, input logic [1:0] size, input logic uns);
        exec_t e;
        e.pc4 = pc4; e.alu = alu; e.rs2 = rs2; e.sel = sel;
        e.rw = rw; e.mw = mw; e.mr = mr; e.size = size; e.uns = uns;
        return e;
    endfunction

    function automatic entry_t ent(input string tag, input bit full, input exec_t e,
                                   input logic [31:0] dout2, input logic mis, berr);
        entry_t r;
        r.tag = tag; r.full = full; r.pc4 = e.pc4; r.alu = e.alu; r.dout2 = dout2;
        r.sel = e.sel; r.rw = full ? e.rw : 1'b0; r.mis = mis; r.berr = berr;
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (size)
            2'd0:    return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic bus_t model_bus(input exec_t e);
        bus_t b;
        b.we   = e.mw;
        b.addr = e.alu & 32'hFFFF_FFFC;
        case (e.size)
            2'd0:    begin b.be = 4'b0001 << e.alu[1:0]; b.wd = {4{e.rs2[7:0]}}; end
            2'd1:    begin b.be = e.alu[1] ? 4'b1100 : 4'b0011; b.wd = {2{e.rs2[15:0]}}; end
            default: begin b.be = 4'b1111; b.wd = e.rs2; end
        endcase
        return b;
    endfunction

    // Capture what the monitor must expect for the entry loaded at this edge.
    always @(posedge clk) begin
        mon_due    = retire_now;
        mon_rst    = !rst_n;
        mon_active = 1'b1;
    end

    // Scoreboard monitor: reset zeros, queued entry, or a bubble every cycle.
    always @(negedge clk) begin
        entry_t e;
        if (mon_active) begin
            n_cmp++;
            if (mon_rst) begin
                if ({MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2, MEM_RF_WR_SEL, MEM_REGWRITE,
                     MEM_MISALIGN, MEM_BUS_ERR} !== '0) begin
                    n_bad++;
                    $display("FAIL mem_wb_reset: got pc4=%h alu=%h dout2=%h sel=%0d rw=%b mis=%b berr=%b, want all zero",
                             MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2, MEM_RF_WR_SEL, MEM_REGWRITE,
                             MEM_MISALIGN, MEM_BUS_ERR);
                end
            end else if (mon_due) begin
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_underflow: got an expected retire with empty queue, want a queued entry");
                end else begin
                    e = sb_q.pop_front();
                    if (e.full) begin
                        if ({MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2, MEM_RF_WR_SEL, MEM_REGWRITE,
                             MEM_MISALIGN, MEM_BUS_ERR} !==
                            {e.pc4, e.alu, e.dout2, e.sel, e.rw, e.mis, e.berr}) begin
                            n_bad++;
                            $display("FAIL %s mem_wb: got pc4=%h alu=%h dout2=%h sel=%0d rw=%b mis=%b berr=%b, want pc4=%h alu=%h dout2=%h sel=%0d rw=%b mis=%b berr=%b",
                                     e.tag, MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2, MEM_RF_WR_SEL,
                                     MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR, e.pc4, e.alu,
                                     e.dout2, e.sel, e.rw, e.mis, e.berr);
                        end
                    end else if ({MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR} !== {1'b0, e.mis, e.berr}) begin
                        n_bad++;
                        $display("FAIL %s mem_wb_flags: got rw=%b mis=%b berr=%b, want rw=0 mis=%b berr=%b",
                                 e.tag, MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR, e.mis, e.berr);
                    end
                end
            end else if ({MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR} !== 3'b000) begin
                n_bad++;
                $display("FAIL bubble: got rw=%b mis=%b berr=%b, want 000",
                         MEM_REGWRITE, MEM_MISALIGN, MEM_BUS_ERR);
            end
        end
    end

    task automatic drive(input exec_t e);
        EXEC_PC_4 = e.pc4; EXEC_PC_MEM = e.pc4 - 32'd4; EXEC_ALU_RESULT = e.alu;
        EXEC_RS2 = e.rs2; EXEC_RF_WR_SEL = e.sel; EXEC_REGWRITE = e.rw;
        EXEC_MEMWRITE = e.mw; EXEC_MEMREAD2 = e.mr; EXEC_MEM_SIZE = e.size;
        EXEC_MEM_UNSIGNED = e.uns;
    endtask

    task automatic idle(input int n);
        drive(nop_ex);
        DMEM_READY = 1'b0;
        retire_now = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one instruction from posedge+1; READY rises at cycle ready_at
    // (-1 = never) and the bench expects the entry to retire at retire_at.
    task automatic run_access(input exec_t e, input logic [31:0] rdata, input int ready_at,
                              input int retire_at, output int req_cyc, output int stall_cyc,
                              output bus_t bus, output bit stable);
        bus_t cur;
        req_cyc = 0; stall_cyc = 0; bus = '0; stable = 1'b1;
        drive(e);
        for (int c = 0; c <= retire_at; c++) begin
            DMEM_READY = (c == ready_at);
            DMEM_RDATA = (c == ready_at) ? rdata : 32'h5A5A_A5A5;
            retire_now = (c == retire_at);
            @(negedge clk);
            cur = {DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA};
            if (DMEM_REQ === 1'b1) begin
                req_cyc++;
                if (req_cyc == 1) bus = cur;
                else if (cur !== bus) stable = 1'b0;
            end
            if (MEM_STALL === 1'b1) stall_cyc++;
            @(posedge clk); #1;
        end
        retire_now = 1'b0;
        DMEM_READY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk(32'h4, 32'h40, 32'h1, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0));
        DMEM_READY = 1'b1; DMEM_RDATA = 32'h1234_5678; retire_now = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (DMEM_REQ !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_req: got req=%b, want 0", DMEM_REQ);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_word_store();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h204, 32'h100, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("word_store", 1'b1, e, 32'h0, 1'b0, 1'b0));
        run_access(e, 32'h0, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL word_store cycles: got req=%0d stall=%0d, want req=1 stall=0", rq, st);
        end
        n_cmp++;
        if ({stb, b} !== {1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL word_store bus: got stable=%b we=%b be=%b addr=%h wd=%h, want 1 1 1111 00000100 deadbeef",
                     stb, b.we, b.be, b.addr, b.wd);
        end
        idle(1);
    endtask

    task automatic test_signed_byte_load();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h208, 32'h103, 32'hA5, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_BYTE, 1'b0);
        sb_q.push_back(ent("sbyte_load", 1'b1, e, 32'hFFFF_FF80, 1'b0, 1'b0));
        run_access(e, 32'h80FF_FF11, 3, 3, rq, st, b, stb);
        n_cmp++;
        if (rq !== 4 || st !== 3) begin
            n_bad++;
            $display("FAIL sbyte_load cycles: got req=%0d stall=%0d, want req=4 stall=3", rq, st);
        end
        n_cmp++;
        if ({stb, b} !== {1'b1, 1'b0, 4'b1000, 32'h100, 32'hA5A5_A5A5}) begin
            n_bad++;
            $display("FAIL sbyte_load bus: got stable=%b we=%b be=%b addr=%h wd=%h, want 1 0 1000 00000100 a5a5a5a5",
                     stb, b.we, b.be, b.addr, b.wd);
        end
        idle(1);
    endtask

    task automatic test_unsigned_half_load();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h20C, 32'h102, 32'h1234_5678, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b1);
        sb_q.push_back(ent("uhalf_load", 1'b1, e, 32'h0000_8001, 1'b0, 1'b0));
        run_access(e, 32'h8001_0000, 1, 1, rq, st, b, stb);
        n_cmp++;
        if (rq !== 2 || st !== 1) begin
            n_bad++;
            $display("FAIL uhalf_load cycles: got req=%0d stall=%0d, want req=2 stall=1", rq, st);
        end
        n_cmp++;
        if ({stb, b} !== {1'b1, 1'b0, 4'b1100, 32'h100, 32'h5678_5678}) begin
            n_bad++;
            $display("FAIL uhalf_load bus: got stable=%b we=%b be=%b addr=%h wd=%h, want 1 0 1100 00000100 56785678",
                     stb, b.we, b.be, b.addr, b.wd);
        end
        idle(1);
    endtask

    task automatic test_misaligned();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h210, 32'h101, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b0);
        sb_q.push_back(ent("mis_half_load", 1'b0, e, 32'h0, 1'b1, 1'b0));
        run_access(e, 32'hFFFF_FFFF, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 0 || st !== 0) begin
            n_bad++;
            $display("FAIL mis_half_load cycles: got req=%0d stall=%0d, want req=0 stall=0", rq, st);
        end
        e = mk(32'h214, 32'h102, 32'h77, 2'd0, 1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("mis_word_store", 1'b0, e, 32'h0, 1'b1, 1'b0));
        run_access(e, 32'h0, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 0 || st !== 0) begin
            n_bad++;
            $display("FAIL mis_word_store cycles: got req=%0d stall=%0d, want req=0 stall=0", rq, st);
        end
        idle(2);
    endtask

    task automatic test_passthrough();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h218, 32'hCAFE_0001, 32'h9, 2'd3, 1'b1, 1'b0, 1'b0, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("alu_pass", 1'b1, e, 32'h0, 1'b0, 1'b0));
        run_access(e, 32'hFFFF_FFFF, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 0 || st !== 0) begin
            n_bad++;
            $display("FAIL alu_pass cycles: got req=%0d stall=%0d, want req=0 stall=0", rq, st);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        exec_t e[4]; logic [31:0] rd[4], dv[4]; int rdy[4];
        int rq, st; bus_t b; bit stb;
        e[0] = mk(32'h300, 32'h200, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        e[1] = mk(32'h304, 32'h206, 32'h0000_BEEF, 2'd0, 1'b0, 1'b1, 1'b0, SIZE_HALF, 1'b0);
        e[2] = mk(32'h308, 32'h20E, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b0);
        e[3] = mk(32'h30C, 32'h210, 32'h0BAD_F00D, 2'd0, 1'b0, 1'b1, 1'b1, SIZE_WORD, 1'b0);
        rd[0] = 32'h1122_3344; rd[1] = 32'h0; rd[2] = 32'h8000_7FFF; rd[3] = 32'h5555_5555;
        dv[0] = 32'h1122_3344; dv[1] = 32'h0; dv[2] = 32'hFFFF_8000; dv[3] = 32'h0;
        rdy[0] = 0; rdy[1] = 0; rdy[2] = 2; rdy[3] = 0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(ent("b2b", 1'b1, e[i], dv[i], 1'b0, 1'b0));
            run_access(e[i], rd[i], rdy[i], rdy[i], rq, st, b, stb);
            n_cmp++;
            if (rq !== rdy[i] + 1 || st !== rdy[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d] cycles: got req=%0d stall=%0d, want req=%0d stall=%0d",
                         i, rq, st, rdy[i] + 1, rdy[i]);
            end
            n_cmp++;
            if ({stb, b} !== {1'b1, model_bus(e[i])}) begin
                n_bad++;
                $display("FAIL b2b[%0d] bus: got stable=%b bus=%h, want stable=1 bus=%h",
                         i, stb, b, model_bus(e[i]));
            end
        end
        idle(1);
    endtask

    task automatic test_random();
        exec_t e; int rq, st, w; bus_t b; bit stb; logic [31:0] rd, a; logic [1:0] sz;
        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(3));
            a  = $urandom & 32'h0000_0FFF;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            e = mk($urandom, a, $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)),
                   1'b0, 1'b0, sz, 1'($urandom_range(1)));
            if ($urandom_range(1) == 1) e.mw = 1'b1; else e.mr = 1'b1;
            rd = $urandom;
            w  = $urandom_range(3);
            sb_q.push_back(ent("rand", 1'b1, e, e.mw ? 32'h0 : model_load(rd, a[1:0], sz, e.uns),
                               1'b0, 1'b0));
            run_access(e, rd, w, w, rq, st, b, stb);
            n_cmp++;
            if (rq !== w + 1 || st !== w || {stb, b} !== {1'b1, model_bus(e)}) begin
                n_bad++;
                $display("FAIL rand[%0d]: got req=%0d stall=%0d stable=%b bus=%h, want req=%0d stall=%0d stable=1 bus=%h",
                         i, rq, st, stb, b, w + 1, w, model_bus(e));
            end
        end
        idle(1);
    endtask

`ifdef MEMORY_TIMEOUT_EN
    task automatic test_timeout();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h400, 32'h300, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("timeout", 1'b0, e, 32'h0, 1'b0, 1'b1));
        run_access(e, 32'h0, -1, TMO, rq, st, b, stb);
        n_cmp++;
        if (rq !== TMO + 1 || st !== TMO) begin
            n_bad++;
            $display("FAIL timeout cycles: got req=%0d stall=%0d, want req=%0d stall=%0d",
                     rq, st, TMO + 1, TMO);
        end
        e = mk(32'h404, 32'h304, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("after_timeout", 1'b1, e, 32'hABCD_0123, 1'b0, 1'b0));
        run_access(e, 32'hABCD_0123, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL after_timeout cycles: got req=%0d stall=%0d, want req=1 stall=0", rq, st);
        end
        idle(1);
    endtask
`else
    task automatic test_long_wait();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h400, 32'h300, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        sb_q.push_back(ent("long_wait", 1'b1, e, 32'h0F0F_F0F0, 1'b0, 1'b0));
        run_access(e, 32'h0F0F_F0F0, 20, 20, rq, st, b, stb);
        n_cmp++;
        if (rq !== 21 || st !== 20) begin
            n_bad++;
            $display("FAIL long_wait cycles: got req=%0d stall=%0d, want req=21 stall=20", rq, st);
        end
        idle(1);
    endtask
`endif

    task automatic test_reset_in_wait();
        exec_t e; int rq, st; bus_t b; bit stb;
        e = mk(32'h500, 32'h0000_0304, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        drive(e);
        DMEM_READY = 1'b0; retire_now = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({DMEM_REQ, MEM_STALL} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_wait first_wait: got req=%b stall=%b, want 1 1", DMEM_REQ, MEM_STALL);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({DMEM_REQ, MEM_STALL} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_wait req_drop: got req=%b stall=%b, want 0 0", DMEM_REQ, MEM_STALL);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(nop_ex);
        @(negedge clk);
        n_cmp++;
        if (DMEM_REQ !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait idle_after: got req=%b, want 0", DMEM_REQ);
        end
        @(posedge clk); #1;
        sb_q.push_back(ent("after_reset", 1'b1, e, 32'h600D_600D, 1'b0, 1'b0));
        run_access(e, 32'h600D_600D, 0, 0, rq, st, b, stb);
        n_cmp++;
        if (rq !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL after_reset cycles: got req=%0d stall=%0d, want req=1 stall=0", rq, st);
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nop_ex = mk(32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, SIZE_BYTE, 1'b0);
        retire_now = 1'b0;
        DMEM_RDATA = 32'h0;
        test_reset();
        test_word_store();
        test_signed_byte_load();
        test_unsigned_half_load();
        test_misaligned();
        test_passthrough();
        test_back_to_back();
        test_random();
`ifdef MEMORY_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_in_wait();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the pipelined OTTER core: the consumer of the execute pipeline register. Takes the registered ALU result, rs2 and control bits, performs at most one data-memory load or store per instruction over a ready/valid style bus, and stalls upstream while the bus is busy. Loads the MEM/WB pipeline register with load data or the pass-through values for writeback.

## Interface
- TIMEOUT_CYCLES, 16: wait-state limit before a bus abort; used only with MEMORY_TIMEOUT_EN.
- MEMORY_CLOCK  in  1  stage clock; every flop updates on the posedge.
- MEMORY_RESET  in  1  reset; synchronous and active-low.
- EXEC_PC_4, EXEC_PC_MEM, EXEC_ALU_RESULT, EXEC_RS2  in  32 each  execute-register values; ALU_RESULT is the data address.
- EXEC_RF_WR_SEL  in  2  writeback mux select.
- EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2  in  1 each  control bits.
- EXEC_MEM_SIZE  in  2  0 byte, 1 half, 2 word; 3 treated as word.
- EXEC_MEM_UNSIGNED  in  1  zero-extend loads when 1.
- DMEM_REQ  out  1  access request.
- DMEM_WE  out  1  1 = store.
- DMEM_ADDR  out  32  word-aligned address, ALU_RESULT with bits [1:0] cleared.
- DMEM_WDATA  out  32  store data replicated across lanes.
- DMEM_BE  out  4  byte enables.
- DMEM_READY  in  1  access complete this cycle.
- DMEM_RDATA  in  32  read word, valid when DMEM_READY = 1.
- MEM_STALL  out  1  freeze the fetch, decode and execute registers.
- MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2  out  32 each  MEM/WB register; DOUT2 is the extended load data.
- MEM_RF_WR_SEL  out  2; MEM_REGWRITE  out  1  MEM/WB control.
- MEM_MISALIGN  out  1  registered one-cycle flag.
- MEM_BUS_ERR  out  1  registered one-cycle flag.

## Operation
- Access = MEMREAD2 or MEMWRITE. If both are set, the store takes priority.
- Misaligned access:
  - Conditions: half with addr[0] = 1; word with addr[1:0] != 0.
  - Behaviour: no request is issued; MEM/WB loads a bubble (REGWRITE = 0); MEM_MISALIGN = 1 for that entry.
- FSM states IDLE and WAIT.
  - IDLE with an aligned access: DMEM_REQ = 1 combinationally.
    - DMEM_READY = 1 in the same cycle: the access completes.
    - Otherwise: next state WAIT.
  - WAIT: DMEM_REQ = 1. On DMEM_READY = 1 the access completes and the FSM returns to IDLE.
- MEM_STALL = DMEM_REQ and not DMEM_READY (combinational). Upstream holds the EXEC_* inputs stable while stalled.
- Request signals are held constant for the whole request. DMEM_READY is ignored while DMEM_REQ = 0.
- While stalled, MEM/WB loads a bubble: REGWRITE = 0, other fields don't-care.
- On completion or a non-access instruction, MEM/WB loads:
  - MEM_PC_4, MEM_ALU_RESULT and MEM_RF_WR_SEL from the inputs;
  - MEM_REGWRITE = EXEC_REGWRITE;
  - MEM_DOUT2 = extracted load data (0 for stores and non-loads).
- Lane rules, with off = addr[1:0]:
  - Byte: BE = 0001 shifted left by off; WDATA = rs2[7:0] replicated four times.
  - Half: BE = 0011 shifted left by off; WDATA = rs2[15:0] replicated twice.
  - Word: BE = 1111; WDATA = rs2.
  - Loads select the byte or half at off, then sign- or zero-extend.
- Reset:
  - All MEM_* outputs are 0, the FSM is IDLE and the counter is 0.
  - DMEM_REQ is forced to 0 while MEMORY_RESET = 0.
  - A reset during WAIT abandons the access with no completion.

## Timing
- Zero-wait access (READY high in the request cycle): no stall; MEM/WB is valid at the next posedge.
- N wait cycles: MEM_STALL is high for N cycles; MEM/WB receives the result at the posedge that samples READY = 1.
- Back-to-back accesses: a new request can start in the cycle after completion; there is no dead cycle.
- MEM_MISALIGN and MEM_BUS_ERR are high for exactly the one cycle their entry occupies MEM/WB.

## Configuration
- MEMORY_TIMEOUT_EN defined:
  - A counter increments each cycle spent in WAIT and is cleared on leaving WAIT.
  - When the count reaches TIMEOUT_CYCLES with READY still low:
    - the access is aborted: the FSM returns to IDLE and DMEM_REQ drops at the next edge;
    - MEM/WB loads a bubble with MEM_BUS_ERR = 1;
    - MEM_STALL is released.
- MEMORY_TIMEOUT_EN undefined: WAIT lasts indefinitely; MEM_BUS_ERR is tied to 0; no counter is built.

## Structure
- Package memory_stage_pkg holds:
  - the FSM state enum;
  - the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - the default TIMEOUT_CYCLES.
- Sub-module mem_lane_align (combinational) holds the BE/WDATA generation, the misalignment check and the load extraction and extension.
- The top level holds the FSM, the counter and the MEM/WB register.

## Test plan
- Word store of 0xDEADBEEF to 0x100 with READY tied high -> one request cycle with WE = 1, BE = 1111, no stall; MEM_REGWRITE = 0.
- Signed byte load from 0x103 with RDATA = 0x80FF_FF11, 3 wait cycles -> MEM_STALL high for 3 cycles, then MEM_DOUT2 = 0xFFFF_FF80 with REGWRITE = 1.
- Unsigned half load from 0x102 with RDATA = 0x8001_0000 -> BE = 1100, MEM_DOUT2 = 0x0000_8001.
- Half load from 0x101 -> no DMEM_REQ, MEM_MISALIGN pulses for 1 cycle, MEM_REGWRITE = 0.
- With MEMORY_TIMEOUT_EN and READY held low -> abort after 16 wait cycles, MEM_BUS_ERR pulses, stall drops, and the next instruction proceeds.
- MEMORY_RESET low in the 2nd wait cycle -> DMEM_REQ drops in that cycle, all MEM_* are 0 at the next edge, and the FSM is IDLE.
